// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC valid/ready register bus.
// Contents:
//   state_t  - arbiter transaction state (IDLE, BUSY, DONE)
//   MST_CPU  - master ID of the CPU data port (master 0)
//   MST_DBG  - master ID of the debug/DMA port (master 1)
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DBG = 1'b1;

endpackage

// File: rtl/gpio_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational.
// Ports:
//   req0, req1 - request lines of master 0 / master 1
//   last       - master that owned the previous transaction
//   gnt        - any request present
//   owner      - selected master; on a tie the one that did not go last
module rr_pick2
  import soc_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic owner
);

  always_comb begin
    gnt = req0 | req1;
    if (req0 && req1) begin
      owner = ~last;
    end else if (req1) begin
      owner = MST_DBG;
    end else begin
      owner = MST_CPU;
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-master, one-slave arbiter for the valid/ready register bus in front of
// the GPIO peripheral. Round-robin grant, one transaction in flight, a DONE
// cycle that swallows the slave's stale ready, and a timeout that completes
// transactions the slave never acknowledges.
// Ports:
//   clk, resetn                      - clock, async active-low reset
//   mN_valid/addr/wdata/wstrb        - master N request (wstrb 0 = read)
//   mN_ready/rdata                   - master N completion pulse and read data
//   s_valid/addr/wdata/wstrb         - request forwarded to the slave
//   s_ready/rdata                    - slave completion and read data
//   timeout_err                      - one-cycle pulse after a forced completion
module gpio_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                timeout_err
);

  localparam int unsigned    TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last, last_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          terr_nx;
  logic          gnt, pick;
  logic          timeout_hit;
  logic          done;

  rr_pick2 u_pick (
    .req0  (m0_valid),
    .req1  (m1_valid),
    .last  (last),
    .gnt   (gnt),
    .owner (pick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      owner       <= MST_CPU;
      last        <= MST_DBG;
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      last        <= last_nx;
      tcnt        <= tcnt_nx;
      timeout_err <= terr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last;
    tcnt_nx     = tcnt;
    terr_nx     = 1'b0;
    timeout_hit = 1'b0;
    done        = 1'b0;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;

    case (state)
      ST_IDLE: begin
        if (gnt) begin
          owner_nx = pick;
          tcnt_nx  = '0;
          state_nx = ST_BUSY;
        end
      end

      ST_BUSY: begin
        timeout_hit = (tcnt == TLAST);
        done        = s_ready | timeout_hit;
        // Valid drops in the completion cycle so the slave never sees a
        // second request while its ready is still asserted.
        s_valid     = ~done;
        tcnt_nx     = tcnt + TW'(1);
        if (owner == MST_CPU) begin
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          s_wstrb  = m0_wstrb;
          m0_ready = done;
          m0_rdata = s_ready ? s_rdata : '0;
        end else begin
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          s_wstrb  = m1_wstrb;
          m1_ready = done;
          m1_rdata = s_ready ? s_rdata : '0;
        end
        if (done) begin
          state_nx = ST_DONE;
          last_nx  = owner;
          // A real ready in the timeout cycle counts as a normal completion.
          terr_nx  = ~s_ready & timeout_hit;
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed self-checking bench for gpio_bus_arbiter.
module tb_gpio_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO     = 15;

  logic                clk = 1'b0;
  logic                resetn;
  logic                m0_valid, m1_valid;
  logic [ADDR_W-1:0]   m0_addr, m1_addr;
  logic [DATA_W-1:0]   m0_wdata, m1_wdata;
  logic [DATA_W/8-1:0] m0_wstrb, m1_wstrb;
  logic                m0_ready, m1_ready;
  logic [DATA_W-1:0]   m0_rdata, m1_rdata;
  logic                s_valid;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_ready;
  logic [DATA_W-1:0]   s_rdata;
  logic                timeout_err;

  int errors = 0;
  int checks = 0;

  gpio_bus_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wstrb    (m0_wstrb),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wstrb    (m1_wstrb),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;

    // Held in reset: every output reads 0.
    #12;
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_m0_ready", 64'(m0_ready), 64'd0);
    chk("rst_m1_ready", 64'(m1_ready), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'd0);
    resetn = 1'b1;

    // Single m0 read at 0x4, slave answers 0xA5 in cycle 2.
    m0_valid = 1'b1; m0_addr = 32'h4; m0_wstrb = 4'h0;
    #1;
    chk("t1_c0_s_valid", 64'(s_valid), 64'd0);
    chk("t1_c0_m0_ready", 64'(m0_ready), 64'd0);
    tick(); #1;
    chk("t1_c1_s_valid", 64'(s_valid), 64'd1);
    chk("t1_c1_s_addr", 64'(s_addr), 64'h4);
    chk("t1_c1_s_wstrb", 64'(s_wstrb), 64'h0);
    chk("t1_c1_m0_ready", 64'(m0_ready), 64'd0);
    tick(); s_ready = 1'b1; s_rdata = 32'hA5; #1;
    chk("t1_c2_m0_ready", 64'(m0_ready), 64'd1);
    chk("t1_c2_m0_rdata", 64'(m0_rdata), 64'hA5);
    chk("t1_c2_m1_ready", 64'(m1_ready), 64'd0);
    chk("t1_c2_m1_rdata", 64'(m1_rdata), 64'd0);
    chk("t1_c2_s_valid", 64'(s_valid), 64'd0);
    tick(); m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0; #1;
    chk("t1_c3_m0_ready", 64'(m0_ready), 64'd0);
    chk("t1_c3_s_valid", 64'(s_valid), 64'd0);
    chk("t1_c3_s_addr", 64'(s_addr), 64'd0);

    // Stale ready: m1 write, slave holds s_ready two cycles.
    tick(); m1_valid = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h33; m1_wstrb = 4'hF; #1;
    chk("t2_c0_s_valid", 64'(s_valid), 64'd0);
    tick(); #1;
    chk("t2_c1_s_valid", 64'(s_valid), 64'd1);
    chk("t2_c1_s_addr", 64'(s_addr), 64'h8);
    chk("t2_c1_s_wdata", 64'(s_wdata), 64'h33);
    chk("t2_c1_s_wstrb", 64'(s_wstrb), 64'hF);
    tick(); s_ready = 1'b1; #1;
    chk("t2_c2_m1_ready", 64'(m1_ready), 64'd1);
    chk("t2_c2_m0_ready", 64'(m0_ready), 64'd0);
    tick(); m1_valid = 1'b0; #1;
    chk("t2_c3_stale_m1_ready", 64'(m1_ready), 64'd0);
    chk("t2_c3_stale_m0_ready", 64'(m0_ready), 64'd0);
    chk("t2_c3_s_valid", 64'(s_valid), 64'd0);
    tick(); s_ready = 1'b0; #1;
    chk("t2_c4_s_valid", 64'(s_valid), 64'd0);
    chk("t2_c4_m1_ready", 64'(m1_ready), 64'd0);

    // Timeout: m1 read, slave silent; rdata must be masked to 0.
    m1_valid = 1'b1; m1_addr = 32'hC; m1_wstrb = 4'h0; s_rdata = 32'hDEAD_BEEF; #1;
    chk("t3_c0_s_valid", 64'(s_valid), 64'd0);
    for (int k = 1; k < int'(TO); k++) begin
      tick(); #1;
      chk("t3_busy_s_valid", 64'(s_valid), 64'd1);
      chk("t3_busy_m1_ready", 64'(m1_ready), 64'd0);
      chk("t3_busy_timeout_err", 64'(timeout_err), 64'd0);
    end
    tick(); #1;
    chk("t3_to_m1_ready", 64'(m1_ready), 64'd1);
    chk("t3_to_m1_rdata", 64'(m1_rdata), 64'd0);
    chk("t3_to_s_valid", 64'(s_valid), 64'd0);
    chk("t3_to_timeout_err", 64'(timeout_err), 64'd0);
    tick(); m1_valid = 1'b0; #1;
    chk("t3_done_timeout_err", 64'(timeout_err), 64'd1);
    chk("t3_done_m1_ready", 64'(m1_ready), 64'd0);
    tick(); m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0; s_rdata = 32'h5A; #1;
    chk("t3_idle_timeout_err", 64'(timeout_err), 64'd0);
    chk("t3_idle_s_valid", 64'(s_valid), 64'd0);
    tick(); #1;
    chk("t3_next_s_valid", 64'(s_valid), 64'd1);
    chk("t3_next_s_addr", 64'(s_addr), 64'h10);
    tick(); s_ready = 1'b1; #1;
    chk("t3_next_m0_ready", 64'(m0_ready), 64'd1);
    chk("t3_next_m0_rdata", 64'(m0_rdata), 64'h5A);
    chk("t3_next_m1_rdata", 64'(m1_rdata), 64'd0);
    chk("t3_next_timeout_err", 64'(timeout_err), 64'd0);
    tick(); m0_valid = 1'b0; s_ready = 1'b0; #1;
    chk("t3_next_done_m0_ready", 64'(m0_ready), 64'd0);

    // Reset mid-BUSY: last owner was m0, so the tie goes to m1 here.
    tick();
    m0_valid = 1'b1; m0_wdata = 32'h11; m0_wstrb = 4'hF; m0_addr = 32'h20;
    m1_valid = 1'b1; m1_wdata = 32'h22; m1_wstrb = 4'hF; m1_addr = 32'h24;
    #1;
    chk("t4_c0_s_valid", 64'(s_valid), 64'd0);
    tick(); #1;
    chk("t4_c1_s_valid", 64'(s_valid), 64'd1);
    chk("t4_c1_s_wdata", 64'(s_wdata), 64'h22);
    tick(); s_ready = 1'b1; #1;
    chk("t4_c2_m1_ready", 64'(m1_ready), 64'd1);
    resetn = 1'b0; #1;
    chk("t4_rst_m1_ready", 64'(m1_ready), 64'd0);
    chk("t4_rst_s_valid", 64'(s_valid), 64'd0);
    chk("t4_rst_s_wdata", 64'(s_wdata), 64'd0);
    chk("t4_rst_timeout_err", 64'(timeout_err), 64'd0);
    tick(); #1;
    chk("t4_rst_hold_s_valid", 64'(s_valid), 64'd0);
    resetn = 1'b1; s_ready = 1'b0;

    // Continuous contention from reset: slave sees 0x11, 0x22, 0x11.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_c0_s_valid", 64'(s_valid), 64'd0);
      tick(); #1;
      chk("t5_c1_s_valid", 64'(s_valid), 64'd1);
      chk("t5_c1_s_wdata", 64'(s_wdata), (i == 1) ? 64'h22 : 64'h11);
      chk("t5_c1_s_addr", 64'(s_addr), (i == 1) ? 64'h24 : 64'h20);
      chk("t5_c1_m0_ready", 64'(m0_ready), 64'd0);
      chk("t5_c1_m1_ready", 64'(m1_ready), 64'd0);
      tick(); s_ready = 1'b1; #1;
      chk("t5_c2_m0_ready", 64'(m0_ready), (i == 1) ? 64'd0 : 64'd1);
      chk("t5_c2_m1_ready", 64'(m1_ready), (i == 1) ? 64'd1 : 64'd0);
      chk("t5_c2_timeout_err", 64'(timeout_err), 64'd0);
      tick(); s_ready = 1'b0; #1;
      chk("t5_c3_m0_ready", 64'(m0_ready), 64'd0);
      chk("t5_c3_m1_ready", 64'(m1_ready), 64'd0);
      chk("t5_c3_s_valid", 64'(s_valid), 64'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
Name: gpio_bus_arbiter

Overview:
Two-master, one-slave arbiter for the SoC's simple valid/ready register bus. It shares the GPIO peripheral between master 0 (CPU data port) and master 1 (debug/DMA port).
- Round-robin grant; one transaction in flight at a time.
- Suppresses the slave's stale ready pulse.
- A timeout completes any transaction the slave never acknowledges.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb width = DATA_W/8)
TIMEOUT_CYCLES, 15, BUSY cycles without s_ready before forced completion (>=2)

Ports:
clk  in  1  clock; all state on rising edge
resetn  in  1  reset, asynchronous and active-low
m0_valid / m1_valid  in  1  request; held with addr/wdata/wstrb until mN_ready
m0_addr / m1_addr  in  ADDR_W  request address
m0_wdata / m1_wdata  in  DATA_W  write data
m0_wstrb / m1_wstrb  in  DATA_W/8  byte strobes; 0 = read
m0_ready / m1_ready  out  1  one-cycle completion pulse to that master
m0_rdata / m1_rdata  out  DATA_W  read data, valid only when mN_ready=1
s_valid  out  1  request to slave
s_addr  out  ADDR_W  forwarded address
s_wdata  out  DATA_W  forwarded write data
s_wstrb  out  DATA_W/8  forwarded strobes
s_ready  in  1  slave completion; may stay high the cycle after valid drops
s_rdata  in  DATA_W  slave read data
timeout_err  out  1  one-cycle pulse with a forced completion

Behaviour:
- Registered state: state {IDLE, BUSY, DONE}, owner (1 bit), last (1 bit), tcnt (clog2(TIMEOUT_CYCLES+1) bits), timeout_err.
- Reset, async on resetn=0, also mid-transaction: state=IDLE, owner=0, last=1, tcnt=0, timeout_err=0. All outputs read 0 while held in reset.
- IDLE: s_ready is ignored.
  - Only m0_valid -> owner=0.
  - Only m1_valid -> owner=1.
  - Both -> owner = ~last.
  - Any request -> state BUSY, tcnt=0. No request -> stay in IDLE.
- BUSY, combinational outputs:
  - s_valid = ~s_ready & ~timeout_hit, where timeout_hit = (tcnt == TIMEOUT_CYCLES-1).
  - s_addr/s_wdata/s_wstrb = owner master's signals.
  - m<owner>_ready = s_ready | timeout_hit.
- BUSY, registered:
  - tcnt increments each cycle.
  - On s_ready or timeout_hit: state DONE, last=owner.
  - If s_ready is low and timeout_hit is high, timeout_err=1 next cycle; s_ready has priority in the same cycle.
- DONE: lasts one cycle, all s_* = 0, s_ready ignored (it absorbs the slave's stale ready), then IDLE. timeout_err is 0 in every cycle other than the pulse.
- In IDLE and DONE, s_addr/s_wdata/s_wstrb are driven to 0.
- Read data:
  - On a normal completion, m<owner>_rdata = s_rdata in the ready cycle.
  - On a timeout completion, m<owner>_rdata = 0.
  - The non-owner's rdata is always 0.
- Latency and throughput:
  - Request seen in IDLE cycle 0 -> s_valid cycle 1 -> earliest mN_ready cycle 2 -> DONE cycle 3 -> IDLE cycle 4.
  - Peak rate is one transaction per 4 cycles.
  - Worst case, mN_ready arrives TIMEOUT_CYCLES cycles after the grant edge.
- Fairness: under continuous contention, grants alternate 0,1,0,1. At the first tie after reset, m0 wins.
- Owner drops valid mid-BUSY (protocol violation): the transaction still completes and the ready pulse is still issued.
- A new request may be asserted during DONE; it is granted in the following IDLE cycle.

Decomposition:
- Shared package (soc_bus_pkg):
  - state encoding localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
  - master IDs MST_CPU=1'b0, MST_DBG=1'b1.
- No sub-module needed. If the grant logic is factored out, name it rr_pick2: pure combinational, (req0, req1, last) -> (gnt, owner).

Test Plan:
- Single read, m0, addr=0x0000_0004, slave returns s_rdata=0xA5 in cycle 2 -> m0_ready pulse in cycle 2 with m0_rdata=0xA5; s_valid high only in cycle 1; IDLE at cycle 4.
- Simultaneous m0 and m1 writes held continuously (wdata 0x11 / 0x22) -> slave sees 0x11, 0x22, 0x11 in that order, spaced 4 cycles apart; each master gets exactly one ready per transaction.
- Slave holds s_ready high 2 cycles (stale pulse) -> a single mN_ready; the stale cycle falls in DONE and produces no extra ready.
- Slave never responds, TIMEOUT_CYCLES=15, m1 read -> m1_ready with m1_rdata=0 exactly 15 cycles after the grant edge; timeout_err pulses once, 1 cycle later; the next m0 request is served normally.
- resetn pulled low mid-BUSY -> s_valid, mN_ready and timeout_err drop immediately (async); after release, a tie goes to m0.
